// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 cache controller control path.
// Holds the controller state encoding and the cache geometry constants.
package l2_pkg;
    localparam int NUM_WAYS    = 4;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 32 - OFFSET_BITS;
    localparam int WAY_BITS    = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } state_t;
endpackage

// File: rtl/l2_plru.sv
// Tree pseudo-LRU for one 4-way set: next bits after touching a way, and the current victim.
// Purely combinational; the per-set bits are stored by the caller.
module l2_plru
    import l2_pkg::*;
(
    input  logic [2:0]          i_bits,
    input  logic [WAY_BITS-1:0] i_touch_way,
    output logic [2:0]          o_bits,
    output logic [WAY_BITS-1:0] o_victim
);
    // bit0 picks the pair (1 = ways 2/3), bit1/bit2 pick within the left/right pair
    always_comb begin
        o_bits = i_bits;
        if (!i_touch_way[1]) begin
            o_bits[0] = 1'b1;
            o_bits[1] = ~i_touch_way[0];
        end else begin
            o_bits[0] = 1'b0;
            o_bits[2] = ~i_touch_way[0];
        end
    end

    assign o_victim = i_bits[0] ? {1'b1, i_bits[2]} : {1'b0, i_bits[1]};
endmodule

// File: rtl/l2_cache_controller.sv
// Tag/valid/dirty/PLRU control path of a 4-way write-back, write-allocate L2 cache.
// Hit served in the cycle after the request is latched; misses wait on ready_MEM_L2 per memory phase.
module l2_cache_controller
    import l2_pkg::*;
#(
    parameter int TNUM   = 18,
    parameter int INUM   = 26 - TNUM,
    parameter int TNUM_2 = 18,
    parameter int INUM_2 = 26 - TNUM_2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [TNUM-1:0]     tag_L1_L2,
    input  logic [INUM-1:0]     index_L1_L2,
    input  logic                read_L1_L2,
    input  logic                write_L1_L2,
    input  logic                flush,
    input  logic                ready_MEM_L2,
    output logic                ready_L2_L1,
    output logic                refill,
    output logic                update,
    output logic                read_L2_MEM,
    output logic                write_L2_MEM,
    output logic [INUM_2-1:0]   index_L2_MEM,
    output logic [TNUM_2-1:0]   tag_L2_MEM,
    output logic [INUM_2-1:0]   write_index_L2_MEM,
    output logic [TNUM_2-1:0]   write_tag_L2_MEM,
    output logic [WAY_BITS-1:0] way
);
    localparam int SETS = 1 << INUM_2;

    state_t                r_state, w_next;
    logic [TNUM_2-1:0]     r_tag;
    logic [INUM_2-1:0]     r_index;
    logic                  r_write;
    logic [WAY_BITS-1:0]   r_victim;
    logic [NUM_WAYS-1:0]   r_valid [SETS];
    logic [NUM_WAYS-1:0]   r_dirty [SETS];
    logic [2:0]            r_plru  [SETS];
    logic [TNUM_2-1:0]     r_tags  [SETS][NUM_WAYS];

    logic [TNUM+INUM-1:0]  w_addr;
    logic                  w_req;
    logic                  w_hit, w_inv_found, w_victim_dirty;
    logic [WAY_BITS-1:0]   w_hit_way, w_inv_way, w_victim, w_plru_victim;
    logic [2:0]            w_plru_next;

    assign w_addr = {tag_L1_L2, index_L1_L2};
    assign w_req  = read_L1_L2 | write_L1_L2;

    // Reverse scan so the lowest-numbered matching/invalid way wins
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[r_index][w] && (r_tags[r_index][w] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(w);
            end
            if (!r_valid[r_index][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_BITS'(w);
            end
        end
    end

    assign w_victim       = w_inv_found ? w_inv_way : w_plru_victim;
    assign w_victim_dirty = r_valid[r_index][w_victim] & r_dirty[r_index][w_victim];

    l2_plru u_plru (
        .i_bits      (r_plru[r_index]),
        .i_touch_way (w_hit_way),
        .o_bits      (w_plru_next),
        .o_victim    (w_plru_victim)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:       if (w_req) w_next = COMPARE;
                COMPARE:    w_next = w_hit ? IDLE : (w_victim_dirty ? WRITE_BACK : ALLOCATE);
                WRITE_BACK: if (ready_MEM_L2) w_next = ALLOCATE;
                ALLOCATE:   if (ready_MEM_L2) w_next = COMPARE;
                default:    w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_L2_L1        = 1'b0;
        update             = 1'b0;
        refill             = 1'b0;
        read_L2_MEM        = 1'b0;
        write_L2_MEM       = 1'b0;
        index_L2_MEM       = '0;
        tag_L2_MEM         = '0;
        write_index_L2_MEM = '0;
        write_tag_L2_MEM   = '0;
        way                = '0;
        case (r_state)
            COMPARE: begin
                ready_L2_L1 = w_hit;
                update      = w_hit & r_write;
                way         = w_hit ? w_hit_way : w_victim;
            end
            WRITE_BACK: begin
                write_L2_MEM       = 1'b1;
                write_index_L2_MEM = r_index;
                write_tag_L2_MEM   = r_tags[r_index][r_victim];
                way                = r_victim;
            end
            ALLOCATE: begin
                read_L2_MEM  = 1'b1;
                index_L2_MEM = r_index;
                tag_L2_MEM   = r_tag;
                way          = r_victim;
                refill       = ready_MEM_L2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_tag    <= '0;
            r_index  <= '0;
            r_write  <= 1'b0;
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_tag   <= w_addr[TNUM+INUM-1 -: TNUM_2];
                    r_index <= w_addr[INUM_2-1:0];
                    r_write <= write_L1_L2;
                end
                COMPARE: begin
                    if (w_hit) begin
                        r_plru[r_index] <= w_plru_next;
                        if (r_write) r_dirty[r_index][w_hit_way] <= 1'b1;
                    end else begin
                        r_victim <= w_victim;
                    end
                end
                WRITE_BACK: if (ready_MEM_L2) r_dirty[r_index][r_victim] <= 1'b0;
                ALLOCATE: if (ready_MEM_L2) begin
                    r_valid[r_index][r_victim] <= 1'b1;
                    r_dirty[r_index][r_victim] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset: every tag is qualified by its valid bit
    always_ff @(posedge clk) begin
        if (!flush && (r_state == ALLOCATE) && ready_MEM_L2)
            r_tags[r_index][r_victim] <= r_tag;
    end
endmodule

// File: tb/tb_l2_cache_controller.sv
// Directed bench for l2_cache_controller with a fixed 3-cycle memory responder.
module tb_l2_cache_controller;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [17:0] tag_L1_L2 = '0;
    logic [7:0]  index_L1_L2 = '0;
    logic        read_L1_L2 = 1'b0, write_L1_L2 = 1'b0, flush = 1'b0, ready_MEM_L2 = 1'b0;
    logic        ready_L2_L1, refill, update, read_L2_MEM, write_L2_MEM;
    logic [7:0]  index_L2_MEM, write_index_L2_MEM;
    logic [17:0] tag_L2_MEM, write_tag_L2_MEM;
    logic [1:0]  way;

    int n_chk = 0, n_pass = 0;

    logic        ob_rd, ob_wb, ob_refill, ob_upd;
    logic [17:0] ob_rd_tag, ob_wb_tag;
    logic [7:0]  ob_rd_idx, ob_wb_idx;
    logic [1:0]  ob_wb_way, ob_refill_way, ob_way;
    int          ob_cycles;

    logic [1:0]  vt [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    l2_cache_controller dut (
        .clk(clk), .nrst(nrst), .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2),
        .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .flush(flush),
        .ready_MEM_L2(ready_MEM_L2), .ready_L2_L1(ready_L2_L1), .refill(refill),
        .update(update), .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
        .index_L2_MEM(index_L2_MEM), .tag_L2_MEM(tag_L2_MEM),
        .write_index_L2_MEM(write_index_L2_MEM), .write_tag_L2_MEM(write_tag_L2_MEM),
        .way(way)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    endtask

    // One L1 access; memory answers 3 cycles into each request phase
    task automatic access(input int t, input int ix, input logic wr);
        int  memcnt = 0;
        logic done = 1'b0;
        ob_rd = 0; ob_wb = 0; ob_refill = 0; ob_upd = 0; ob_cycles = 0;
        ob_rd_tag = '0; ob_wb_tag = '0; ob_rd_idx = '0; ob_wb_idx = '0;
        ob_wb_way = '0; ob_refill_way = '0; ob_way = '0;
        @(negedge clk);
        tag_L1_L2 = 18'(t); index_L1_L2 = 8'(ix);
        write_L1_L2 = wr; read_L1_L2 = !wr;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            ready_MEM_L2 = 1'b0;
            if (read_L2_MEM || write_L2_MEM) begin
                memcnt++;
                if (memcnt == 3) begin ready_MEM_L2 = 1'b1; memcnt = 0; end
            end
            #1;
            if (write_L2_MEM && !ob_wb) begin
                ob_wb = 1; ob_wb_tag = write_tag_L2_MEM; ob_wb_idx = write_index_L2_MEM; ob_wb_way = way;
            end
            if (read_L2_MEM && !ob_rd) begin
                ob_rd = 1; ob_rd_tag = tag_L2_MEM; ob_rd_idx = index_L2_MEM;
            end
            if (refill) begin ob_refill = 1; ob_refill_way = way; end
            if (update) ob_upd = 1;
            if (ready_L2_L1) begin done = 1'b1; ob_way = way; ob_cycles = c + 1; end
        end
        read_L1_L2 = 1'b0; write_L1_L2 = 1'b0; ready_MEM_L2 = 1'b0;
    endtask

    task automatic chk_acc(input string nm, input int cyc, input logic rd, input logic wb,
                           input logic upd, input logic [1:0] w);
        chk({nm, "_cycles"}, 64'(ob_cycles), 64'(cyc));
        chk({nm, "_rdmem"}, ob_rd, rd);
        chk({nm, "_wrmem"}, ob_wb, wb);
        chk({nm, "_refill"}, ob_refill, rd);
        chk({nm, "_update"}, ob_upd, upd);
        chk({nm, "_way"}, ob_way, w);
        if (rd) chk({nm, "_refill_way"}, ob_refill_way, w);
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_flags", {ready_L2_L1, refill, update, read_L2_MEM, write_L2_MEM, way}, 0);
        chk("reset_addr", {index_L2_MEM, tag_L2_MEM, write_index_L2_MEM, write_tag_L2_MEM}, 0);
        @(negedge clk); nrst = 1'b0;

        // Cold fill: lowest invalid way first
        for (int i = 0; i < 16; i++) begin
            access(100 + i / 4, i % 4, 1'b0);
            chk_acc($sformatf("cold%0d", i), 5, 1, 0, 0, 2'(i / 4));
            chk($sformatf("cold%0d_rdtag", i), ob_rd_tag, 64'(100 + i / 4));
            chk($sformatf("cold%0d_rdidx", i), ob_rd_idx, 64'(i % 4));
        end

        for (int i = 0; i < 16; i++) begin
            access(100 + i / 4, i % 4, 1'b0);
            chk_acc($sformatf("hit%0d", i), 1, 0, 0, 0, 2'(i / 4));
        end

        // Clean replacement follows tree-PLRU order 0,2,1,3
        for (int i = 0; i < 16; i++) begin
            access(200 + i / 4, i % 4, 1'b0);
            chk_acc($sformatf("clean%0d", i), 5, 1, 0, 0, vt[i / 4]);
        end

        do_flush();
        for (int i = 0; i < 16; i++) begin
            access(300 + i / 4, i % 4, 1'b1);
            chk_acc($sformatf("wmiss%0d", i), 5, 1, 0, 1, 2'(i / 4));
        end
        access(300, 1, 1'b0);
        chk_acc("rehit", 1, 0, 0, 0, 2'd0);
        access(301, 1, 1'b1);
        chk_acc("whit", 1, 0, 0, 1, 2'd1);

        // Dirty replacement on set 0
        for (int j = 0; j < 4; j++) begin
            access(400 + j, 0, 1'b0);
            chk_acc($sformatf("dirty%0d", j), 8, 1, 1, 0, vt[j]);
            chk($sformatf("dirty%0d_wbtag", j), ob_wb_tag, 64'(300 + vt[j]));
            chk($sformatf("dirty%0d_wbidx", j), ob_wb_idx, 0);
            chk($sformatf("dirty%0d_wbway", j), ob_wb_way, vt[j]);
            chk($sformatf("dirty%0d_rdtag", j), ob_rd_tag, 64'(400 + j));
        end

        // Flush while refilling
        @(negedge clk); tag_L1_L2 = 18'd500; index_L1_L2 = 8'd0; read_L1_L2 = 1'b1;
        for (int c = 0; c < 10 && !read_L2_MEM; c++) @(negedge clk);
        chk("fa_in_alloc", read_L2_MEM, 1);
        flush = 1'b1; read_L1_L2 = 1'b0;
        @(negedge clk); flush = 1'b0;
        chk("fa_outputs", {read_L2_MEM, write_L2_MEM, refill, ready_L2_L1, update}, 0);
        access(400, 0, 1'b0);
        chk_acc("fa_reread", 5, 1, 0, 0, 2'd0);
        access(302, 2, 1'b0);
        chk_acc("fa_nodirty", 5, 1, 0, 0, 2'd0);

        // Reset in the middle of a write-back
        for (int j = 0; j < 4; j++) begin
            access(600 + j, 3, 1'b1);
            chk_acc($sformatf("rfill%0d", j), 5, 1, 0, 1, 2'(j));
        end
        @(negedge clk); tag_L1_L2 = 18'd604; index_L1_L2 = 8'd3; read_L1_L2 = 1'b1;
        for (int c = 0; c < 10 && !write_L2_MEM; c++) @(negedge clk);
        chk("rst_in_wb", write_L2_MEM, 1);
        chk("rst_wb_tag", write_tag_L2_MEM, 600);
        nrst = 1'b1; read_L1_L2 = 1'b0;
        #1;
        chk("rst_flags", {ready_L2_L1, refill, update, read_L2_MEM, write_L2_MEM, way}, 0);
        chk("rst_addr", {index_L2_MEM, tag_L2_MEM, write_index_L2_MEM, write_tag_L2_MEM}, 0);
        @(negedge clk); nrst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {read_L2_MEM, write_L2_MEM, ready_L2_L1}, 0);
        access(600, 3, 1'b0);
        chk_acc("post_rst_miss", 5, 1, 0, 0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
